// File: rtl/fu_issue_arbiter_if.sv
// fu_issue_arbiter_if: request, functional-unit and response signals of the warp issue arbiter.
interface fu_issue_arbiter_if #(
    parameter int NUM_WARPS     = 4,
    parameter int MACHINE_WIDTH = 32
);
    localparam int WW = $clog2(NUM_WARPS);
    logic [NUM_WARPS-1:0]               req_valid;
    logic [NUM_WARPS-1:0]               req_ready;
    logic [5*NUM_WARPS-1:0]             req_op;
    logic [MACHINE_WIDTH*NUM_WARPS-1:0] req_a;
    logic [MACHINE_WIDTH*NUM_WARPS-1:0] req_b;
    logic                               fu_enable;
    logic [4:0]                         fu_alu_op;
    logic [MACHINE_WIDTH-1:0]           fu_a;
    logic [MACHINE_WIDTH-1:0]           fu_b;
    logic [MACHINE_WIDTH-1:0]           fu_result;
    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [WW-1:0]                      rsp_warp;
    logic [MACHINE_WIDTH-1:0]           rsp_data;
    modport master (
        output req_valid, req_op, req_a, req_b, fu_result, rsp_ready,
        input  req_ready, fu_enable, fu_alu_op, fu_a, fu_b, rsp_valid, rsp_warp, rsp_data
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, fu_result, rsp_ready,
        output req_ready, fu_enable, fu_alu_op, fu_a, fu_b, rsp_valid, rsp_warp, rsp_data
    );
endinterface

// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter: round-robin warp arbiter feeding one functional unit (IDLE/EXEC/RESP).
// Define FU_ARB_PERF_EN to add the saturating perf_busy cycle counter.
module fu_issue_arbiter #(
    parameter int NUM_WARPS     = 4,
    parameter int MACHINE_WIDTH = 32,
    parameter int MULDIV_LAT    = 4
) (
    input logic               clk,
    input logic               reset,
    fu_issue_arbiter_if.slave bus
`ifdef FU_ARB_PERF_EN
    ,
    output logic [31:0]       perf_busy
`endif
);
    localparam int WW = $clog2(NUM_WARPS);
    localparam int CW = $clog2(MULDIV_LAT);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t                   state_q;
    logic [WW-1:0]            rr_ptr_q, warp_q;
    logic [CW-1:0]            cnt_q;
    logic [4:0]               op_q;
    logic [MACHINE_WIDTH-1:0] a_q, b_q, data_q;
    logic                     fu_en_q, rsp_valid_q;
    logic [WW-1:0]            gnt_d;
    logic                     found_d, fire_d, muldiv_d;
    logic [NUM_WARPS-1:0]     ready_d;
    logic [4:0]               op_d;

    function automatic logic [WW-1:0] wrap_add(input logic [WW-1:0] p, input int i);
        int s = int'(p) + i;
        return WW'(s >= NUM_WARPS ? s - NUM_WARPS : s);
    endfunction

    // Scan from the farthest offset down so the warp nearest rr_ptr wins.
    always_comb begin
        gnt_d   = '0;
        found_d = 1'b0;
        ready_d = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (bus.req_valid[wrap_add(rr_ptr_q, i)]) begin
                gnt_d   = wrap_add(rr_ptr_q, i);
                found_d = 1'b1;
            end
        end
        if (reset && state_q == IDLE && found_d) ready_d[gnt_d] = 1'b1;
    end

    assign fire_d   = |(bus.req_valid & ready_d);
    assign op_d     = bus.req_op[int'(gnt_d)*5 +: 5];
    assign muldiv_d = op_d inside {5'b01000, 5'b01001, 5'b01010};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            warp_q      <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            data_q      <= '0;
            fu_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (fire_d) begin
                    state_q  <= EXEC;
                    fu_en_q  <= 1'b1;
                    op_q     <= op_d;
                    a_q      <= bus.req_a[int'(gnt_d)*MACHINE_WIDTH +: MACHINE_WIDTH];
                    b_q      <= bus.req_b[int'(gnt_d)*MACHINE_WIDTH +: MACHINE_WIDTH];
                    warp_q   <= gnt_d;
                    rr_ptr_q <= wrap_add(gnt_d, 1);
                    cnt_q    <= muldiv_d ? CW'(MULDIV_LAT - 1) : '0;
                end
                EXEC: if (cnt_q == '0) begin
                    state_q     <= RESP;
                    fu_en_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    data_q      <= bus.fu_result;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                RESP: if (bus.rsp_ready) begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_d;
    assign bus.fu_enable = fu_en_q;
    assign bus.fu_alu_op = fu_en_q ? op_q : 5'd0;
    assign bus.fu_a      = a_q;
    assign bus.fu_b      = b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_warp  = warp_q;
    assign bus.rsp_data  = data_q;

`ifdef FU_ARB_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_q <= '0;
        else if (state_q != IDLE && ~&perf_q) perf_q <= perf_q + 1'b1;
    end
    assign perf_busy = perf_q;
`endif
endmodule

// File: tb/tb_fu_issue_arbiter.sv
// tb_fu_issue_arbiter: directed and random checks against a transaction-timing reference model.
module tb_fu_issue_arbiter;
    localparam int N = 4, MW = 32, L = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fu_issue_arbiter_if #(.NUM_WARPS(N), .MACHINE_WIDTH(MW)) bus();
`ifdef FU_ARB_PERF_EN
    logic [31:0] perf_busy;
`endif
    fu_issue_arbiter #(.NUM_WARPS(N), .MACHINE_WIDTH(MW), .MULDIV_LAT(L)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FU_ARB_PERF_EN
        ,
        .perf_busy(perf_busy)
`endif
    );

    logic [4:0]    op [N];
    logic [MW-1:0] ra [N];
    logic [MW-1:0] rb [N];
    logic [N-1:0]  pend = '0;
    logic          rsp_rdy = 1'b1;
    bit            keep = 0;

    function automatic logic [MW-1:0] fu_f(input logic [4:0] o, input logic [MW-1:0] a, input logic [MW-1:0] b);
        case (o)
            5'b00001: return a + b;
            5'b01000: return a * b;
            5'b01001: return b == 0 ? '1 : a / b;
            5'b01010: return b == 0 ? a : a % b;
            default:  return a ^ b ^ {27'd0, o};
        endcase
    endfunction

    genvar g;
    for (g = 0; g < N; g++) begin : pack
        assign bus.req_op[5*g +: 5]   = op[g];
        assign bus.req_a[MW*g +: MW]  = ra[g];
        assign bus.req_b[MW*g +: MW]  = rb[g];
    end
    assign bus.req_valid = pend;
    assign bus.rsp_ready = rsp_rdy;
    assign bus.fu_result = bus.fu_enable ? fu_f(bus.fu_alu_op, bus.fu_a, bus.fu_b) : 32'hDEAD_BEEF;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, m_gcyc = 0, m_lat = 0, m_warp = 0, m_rr = 0, exp_g = -1;
    bit m_busy = 0;
    logic [4:0] m_op;
    logic [MW-1:0] m_a, m_b;
    int gnt_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    // A grant at cycle g drives the FU for cycles g+1..g+lat-1 and responds from g+lat.
    task automatic check_outputs();
        int d;
        logic [N-1:0] er;
        bit fen, rv;
        d = cyc - m_gcyc;
        exp_g = m_busy ? -1 : pick(pend, m_rr);
        er = '0;
        if (exp_g >= 0) er[exp_g] = 1'b1;
        fen = m_busy && d < m_lat;
        rv = m_busy && d >= m_lat;
        chk("req_ready", bus.req_ready, er);
        chk("fu_enable", bus.fu_enable, fen);
        chk("fu_alu_op", bus.fu_alu_op, fen ? m_op : 5'd0);
        chk("rsp_valid", bus.rsp_valid, rv);
        if (fen) begin
            chk("fu_a", bus.fu_a, m_a);
            chk("fu_b", bus.fu_b, m_b);
        end
        if (rv) begin
            chk("rsp_warp", bus.rsp_warp, m_warp);
            chk("rsp_data", bus.rsp_data, fu_f(m_op, m_a, m_b));
        end
    endtask

    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        if (!m_busy && exp_g >= 0) begin
            m_busy = 1;
            m_gcyc = cyc;
            m_warp = exp_g;
            m_op = op[exp_g];
            m_a = ra[exp_g];
            m_b = rb[exp_g];
            m_lat = (op[exp_g] inside {5'b01000, 5'b01001, 5'b01010}) ? L + 1 : 2;
            m_rr = (exp_g + 1) % N;
            gnt_log.push_back(exp_g);
            if (!keep) pend[exp_g] = 1'b0;
        end else if (m_busy && cyc - m_gcyc >= m_lat && rsp_rdy) begin
            m_busy = 0;
        end
        cyc++;
    endtask

    task automatic drain();
        rsp_rdy = 1'b1;
        for (int i = 0; i < 80 && (m_busy || pend != 0); i++) step();
        chk("drain_idle", {bus.fu_enable, bus.rsp_valid, pend}, '0);
    endtask

    task automatic do_reset();
        pend = '1;
        reset = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_ready, '0);
        chk("rst_fu_enable", bus.fu_enable, 0);
        chk("rst_fu_alu_op", bus.fu_alu_op, 0);
        chk("rst_fu_a", bus.fu_a, 0);
        chk("rst_fu_b", bus.fu_b, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_warp", bus.rsp_warp, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
`ifdef FU_ARB_PERF_EN
        chk("rst_perf_busy", perf_busy, 0);
`endif
        m_busy = 0;
        m_rr = 0;
        @(negedge clk);
        pend = '0;
        reset = 1'b1;
    endtask

    initial begin
        int base, g0, n_en;
        logic [MW-1:0] snap_d;
        logic [1:0] snap_w;
        logic [4:0] ops [6] = '{5'b00001, 5'b00000, 5'b01000, 5'b01001, 5'b01010, 5'b11111};
        for (int w = 0; w < N; w++) begin
            op[w] = 5'b00001;
            ra[w] = '0;
            rb[w] = '0;
        end
        #2;
        do_reset();

        // one add then one mul: 2 + 5 busy cycles
        ra[0] = 3; rb[0] = 4; pend = 4'b0001;
        drain();
        op[1] = 5'b01000; ra[1] = 9; rb[1] = 9; pend = 4'b0010;
        drain();
`ifdef FU_ARB_PERF_EN
        chk("perf_busy", perf_busy, 7);
`endif

        // round-robin from a fresh pointer
        do_reset();
        for (int w = 0; w < N; w++) begin
            ra[w] = $urandom; rb[w] = $urandom;
        end
        keep = 1;
        pend = '1;
        base = gnt_log.size();
        for (int i = 0; i < 40 && gnt_log.size() < base + 5; i++) step();
        keep = 0;
        pend = '0;
        drain();
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order%0d", i), gnt_log.size() > base + i ? gnt_log[base + i] : -1, i % N);

        // single add on warp 2
        op[2] = 5'b00001; ra[2] = 5; rb[2] = 7; pend = 4'b0100;
        step();
        step();
        chk("add_valid", bus.rsp_valid, 1);
        chk("add_warp", bus.rsp_warp, 2);
        chk("add_data", bus.rsp_data, 12);
        drain();

        // multi-cycle mul on warp 1 with another warp waiting
        op[1] = 5'b01000; ra[1] = 6; rb[1] = 7; pend = 4'b0010;
        g0 = cyc;
        step();
        op[0] = 5'b00001; ra[0] = 1; rb[0] = 1; pend[0] = 1'b1;
        n_en = 0;
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) begin
            n_en += int'(bus.fu_enable);
            step();
        end
        chk("mul_en_cycles", n_en, 4);
        chk("mul_latency", cyc - g0, 5);
        chk("mul_data", bus.rsp_data, 42);
        drain();

        // response backpressure
        op[3] = 5'b00001; ra[3] = 100; rb[3] = 23; pend = 4'b1000;
        step();
        step();
        pend = 4'b0111;
        rsp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) step();
        snap_d = bus.rsp_data;
        snap_w = bus.rsp_warp;
        chk("bp_valid", bus.rsp_valid, 1);
        chk("bp_data", snap_d, 123);
        chk("bp_warp", snap_w, 3);
        rsp_rdy = 1'b1;
        step();
        chk("bp_release", bus.rsp_valid, 0);
        drain();

        // reset during a divide
        op[3] = 5'b01001; ra[3] = 100; rb[3] = 7; pend = 4'b1000;
        step();
        step();
        do_reset();
        for (int i = 0; i < 6; i++) step();
        pend = '1;
        step();
        chk("post_reset_first", gnt_log[$], 0);
        pend = '0;
        drain();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int w = 0; w < N; w++) begin
                if (!pend[w] && $urandom_range(2) == 0) begin
                    op[w] = ops[$urandom_range(5)];
                    ra[w] = $urandom;
                    rb[w] = $urandom_range(3) == 0 ? '0 : $urandom;
                    pend[w] = 1'b1;
                end
            end
            rsp_rdy = $urandom_range(3) != 0;
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
